vector_mask_sequencer: RTL and testbench
========================================

# vector_mask_sequencer

Upstream feeder for the vector merge unit. Latches a full v0 mask, the active vl and vsew for one vector instruction, then emits one 16-bit per-chunk mask slice per 128-bit datapath chunk over a valid/ready handshake. Slice bit j lines up with element j of the chunk, which is the bit layout the merge stage's `vmask_i` consumes. A body-enable slice marks elements below vl so writeback can protect tail elements.

## Interface
Parameters:
- `VLEN`, 512: vector register width in bits.
- `DLEN`, 128: datapath chunk width in bits; fixed at 128. `NCHUNK = VLEN/DLEN`.
- `MAXEL`, `VLEN/8`: maximum element count (SEW=8, LMUL=1); mask width.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: begin an instruction; accepted only in IDLE.
- `vsew_i` in 3: element width, 000=8, 001=16, 010=32, 011=64 bits.
- `vl_i` in `$clog2(MAXEL)+1`: active vector length in elements.
- `vm_i` in 1: 1 = unmasked; the latched mask is treated as all ones.
- `vmask_i` in `MAXEL`: v0 mask, bit i belongs to element i.
- `busy_o` out 1: high whenever state is not IDLE.
- `slice_valid_o` out 1: slice outputs are valid.
- `slice_ready_i` in 1: consumer accepts the slice.
- `slice_mask_o` out 16: per-element select for the current chunk.
- `slice_body_o` out 16: element index < vl.
- `slice_idx_o` out `$clog2(NCHUNK)`: chunk number.
- `slice_last_o` out 1: current slice is the final one.
- `done_o` out 1: one-cycle completion pulse.

## Operation
- **Element count and length.**
  - E = 16 >> vsew gives 16/8/4/2 elements per chunk.
  - Effective length `vle = min(vl_i, NCHUNK*E)`.
  - vsew > 3 is treated as vle = 0.
- **Capture.** A start accepted in IDLE latches vsew, vle and the mask (all ones if `vm_i`).
- **Slice count.** Slices emitted = ceil(vle/E), with indices 0..N-1 in order.
- **Slice contents for chunk k:**
  - `slice_mask_o[j] = mask[k*E+j]` for j < E; bits j >= E are 0.
  - `slice_body_o[j] = (k*E+j < vle)` for j < E; bits j >= E are 0.
  - `slice_last_o = (k == N-1)`.
- **FSM: IDLE, RUN, DONE.**
  - IDLE → RUN when `start_i` is high and vle > 0.
  - IDLE → DONE when `start_i` is high and vle = 0.
  - RUN → DONE on a handshake of the last slice.
  - DONE → IDLE unconditionally.
- **Start outside IDLE.** `start_i` is ignored in RUN and DONE. Inputs sampled outside a start have no effect.
- **Chunk counter.** Increments on each `slice_valid_o && slice_ready_i`. Clears on entry to IDLE.

## Timing
- **Reset.** On `rst_i`, asynchronously:
  - State goes to IDLE.
  - All outputs go to 0: `busy_o`, `slice_valid_o`, `slice_mask_o`, `slice_body_o`, `slice_idx_o`, `slice_last_o`, `done_o`.
  - Latched fields clear.
  - A reset mid-instruction abandons it with no `done_o`.
- **First slice.** `slice_valid_o` rises the cycle after start is accepted. All outputs are registered.
- **Throughput.** One slice per cycle while `slice_ready_i` is held high. An N-slice instruction with ready held high shows `done_o` N+1 cycles after start.
- **Backpressure.** While `slice_valid_o && !slice_ready_i`, all slice outputs hold stable. Valid never drops without a handshake.
- **Done and next start.**
  - `done_o` is high exactly during DONE, the cycle after the last handshake; `slice_valid_o` is 0 then.
  - For vle = 0, `done_o` is high the cycle after start.
  - A new start is accepted earliest the cycle after DONE.

## Configuration
- `VMASK_SEQ_BODY_GATE_EN`:
  - Defined: `slice_mask_o` = mask AND body, so tail elements always select the vs2 / old-value side.
  - Undefined: `slice_mask_o` carries raw mask bits, and tail information is on `slice_body_o` only.
- `slice_body_o` is identical in both builds.

## Structure
- **`vector_pkg`** holds:
  - SEW encodings.
  - The `DLEN` constant.
  - An elements-per-chunk function (16 >> vsew, 0 for illegal).
  - The FSM state enum.
- **Sub-module `vector_mask_slice_extract`** (combinational): takes the latched mask, vle, vsew and chunk index, and produces the mask and body slices. The sequencer registers its outputs.

## Test plan
- **SEW=8, masked, full length.** vsew=0, vl=64, vm=0, vmask=0x0123_4567_89AB_CDEF, ready high → 4 slices, masks 0xCDEF, 0x89AB, 0x4567, 0x0123; body 0xFFFF each; last on idx 3; done at cycle 5.
- **SEW=32, partial length.** vsew=2, vl=6, vm=0, vmask=0x3F → 2 slices, masks 0xF and 0x3, body 0xF and 0x3; with `VMASK_SEQ_BODY_GATE_EN` and vmask=0xFF, slice 1 mask = 0x3.
- **Unmasked, clamped length.** vm=1, vsew=3, vl=9 → vle clamps to 8, 4 slices, mask 0x3, body 0x3 each.
- **Backpressure.** SEW=16 run, ready low for 3 cycles on slice 1 → slice 1 outputs held constant, no slice skipped or duplicated.
- **vl=0, illegal vsew, ignored start.**
  - vl=0 → no valid, `done_o` the next cycle.
  - vsew=5 → same behaviour.
  - `start_i` while busy → ignored.
- **Reset mid-run.** `rst_i` pulsed after slice 1 → all outputs 0 immediately, no done; a new start then runs cleanly.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared types and helpers for the vector mask sequencer: SEW encodings,
// datapath chunk width, elements-per-chunk lookup and the sequencer FSM states.
package vector_pkg;

    localparam int DLEN    = 128;
    localparam int SLICE_W = DLEN / 8;

    typedef enum logic [2:0] {
        SEW_8  = 3'd0,
        SEW_16 = 3'd1,
        SEW_32 = 3'd2,
        SEW_64 = 3'd3
    } sew_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Elements held by one DLEN chunk; 0 flags a reserved vsew encoding.
    function automatic logic [4:0] elems_per_chunk(input logic [2:0] vsew);
        logic [4:0] n_el;
        case (vsew)
            SEW_8:   n_el = 5'd16;
            SEW_16:  n_el = 5'd8;
            SEW_32:  n_el = 5'd4;
            SEW_64:  n_el = 5'd2;
            default: n_el = 5'd0;
        endcase
        return n_el;
    endfunction

endpackage

// File: rtl/vector_mask_slice_extract.sv
// Combinational slice extractor: mask/body bits for one chunk plus last-chunk flag.
// With VMASK_SEQ_BODY_GATE_EN defined the mask slice is ANDed with the body slice.
module vector_mask_slice_extract
    import vector_pkg::*;
#(
    parameter int MAXEL = 64,
    parameter int IDXW  = 2,
    parameter int VLW   = 7
) (
    input  logic [MAXEL-1:0]   i_mask,
    input  logic [VLW-1:0]     i_vle,
    input  logic [2:0]         i_vsew,
    input  logic [IDXW-1:0]    i_idx,
    output logic [SLICE_W-1:0] o_mask,
    output logic [SLICE_W-1:0] o_body,
    output logic               o_last
);

    logic [4:0]       w_n_el;
    logic [MAXEL-1:0] w_mask_sh;
    int               w_base;

    assign w_n_el    = elems_per_chunk(i_vsew);
    assign w_base    = int'(i_idx) * int'(w_n_el);
    assign w_mask_sh = i_mask >> w_base;

    // Element j of the chunk is element base+j of the register.
    always_comb begin
        o_mask = '0;
        o_body = '0;
        o_last = ((int'(i_idx) + 1) * int'(w_n_el)) >= int'(i_vle);
        for (int j = 0; j < SLICE_W; j++) begin
            if (j < int'(w_n_el)) begin
                o_body[j] = (w_base + j) < int'(i_vle);
`ifdef VMASK_SEQ_BODY_GATE_EN
                o_mask[j] = w_mask_sh[j] & o_body[j];
`else
                o_mask[j] = w_mask_sh[j];
`endif
            end else begin
                o_body[j] = 1'b0;
                o_mask[j] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vector_mask_sequencer.sv
// Latches v0 mask, vl and vsew for one instruction and streams per-chunk mask/body
// slices over valid/ready. Optional build macro: VMASK_SEQ_BODY_GATE_EN.
module vector_mask_sequencer
    import vector_pkg::*;
#(
    parameter int VLEN   = 512,
    parameter int DLEN   = vector_pkg::DLEN,
    parameter int MAXEL  = VLEN / 8,
    localparam int NCHUNK = VLEN / DLEN,
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1,
    localparam int VLW    = $clog2(MAXEL) + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [2:0]         vsew_i,
    input  logic [VLW-1:0]     vl_i,
    input  logic               vm_i,
    input  logic [MAXEL-1:0]   vmask_i,
    output logic               busy_o,
    output logic               slice_valid_o,
    input  logic               slice_ready_i,
    output logic [SLICE_W-1:0] slice_mask_o,
    output logic [SLICE_W-1:0] slice_body_o,
    output logic [IDXW-1:0]    slice_idx_o,
    output logic               slice_last_o,
    output logic               done_o
);

    seq_state_e         r_state;
    logic [2:0]         r_vsew;
    logic [VLW-1:0]     r_vle;
    logic [MAXEL-1:0]   r_mask;
    logic [IDXW-1:0]    r_idx;
    logic               r_busy;
    logic               r_valid;
    logic [SLICE_W-1:0] r_smask;
    logic [SLICE_W-1:0] r_sbody;
    logic               r_slast;
    logic               r_done;

    logic [4:0]         w_n_el_in;
    logic [VLW-1:0]     w_vle_in;
    logic [MAXEL-1:0]   w_mask_in;
    logic               w_idle;
    logic [MAXEL-1:0]   w_ex_mask;
    logic [VLW-1:0]     w_ex_vle;
    logic [2:0]         w_ex_vsew;
    logic [IDXW-1:0]    w_ex_idx;
    logic [SLICE_W-1:0] w_slc_mask;
    logic [SLICE_W-1:0] w_slc_body;
    logic               w_slc_last;

    assign w_n_el_in = elems_per_chunk(vsew_i);
    assign w_mask_in = vm_i ? {MAXEL{1'b1}} : vmask_i;

    // Clamp vl to the register capacity at this SEW; reserved vsew gives capacity 0.
    always_comb begin
        int cap;
        cap = NCHUNK * int'(w_n_el_in);
        if (int'(vl_i) > cap) begin
            w_vle_in = VLW'(cap);
        end else begin
            w_vle_in = vl_i;
        end
    end

    // In IDLE the extractor previews chunk 0 of the incoming instruction so the
    // first slice is ready the cycle after start; in RUN it previews the next chunk.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_ex_mask = w_idle ? w_mask_in : r_mask;
    assign w_ex_vle  = w_idle ? w_vle_in  : r_vle;
    assign w_ex_vsew = w_idle ? vsew_i    : r_vsew;
    assign w_ex_idx  = w_idle ? {IDXW{1'b0}} : (r_idx + {{(IDXW-1){1'b0}}, 1'b1});

    vector_mask_slice_extract #(
        .MAXEL (MAXEL),
        .IDXW  (IDXW),
        .VLW   (VLW)
    ) u_extract (
        .i_mask (w_ex_mask),
        .i_vle  (w_ex_vle),
        .i_vsew (w_ex_vsew),
        .i_idx  (w_ex_idx),
        .o_mask (w_slc_mask),
        .o_body (w_slc_body),
        .o_last (w_slc_last)
    );

    // Sequencer FSM with registered slice, busy and done outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_vsew  <= 3'd0;
            r_vle   <= '0;
            r_mask  <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_smask <= '0;
            r_sbody <= '0;
            r_slast <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_vsew <= vsew_i;
                        r_vle  <= w_vle_in;
                        r_mask <= w_mask_in;
                        r_busy <= 1'b1;
                        r_idx  <= '0;
                        if (w_vle_in != '0) begin
                            r_state <= ST_RUN;
                            r_valid <= 1'b1;
                            r_smask <= w_slc_mask;
                            r_sbody <= w_slc_body;
                            r_slast <= w_slc_last;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (r_valid && slice_ready_i) begin
                        r_idx <= r_idx + {{(IDXW-1){1'b0}}, 1'b1};
                        if (r_slast) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b0;
                            r_smask <= '0;
                            r_sbody <= '0;
                            r_slast <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_smask <= w_slc_mask;
                            r_sbody <= w_slc_body;
                            r_slast <= w_slc_last;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_idx   <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign busy_o        = r_busy;
    assign slice_valid_o = r_valid;
    assign slice_mask_o  = r_smask;
    assign slice_body_o  = r_sbody;
    assign slice_idx_o   = r_idx;
    assign slice_last_o  = r_slast;
    assign done_o        = r_done;

endmodule

// File: tb/tb_vector_mask_sequencer.sv
// Table-driven bench for vector_mask_sequencer with a slice scoreboard queue.
// Expectations follow VMASK_SEQ_BODY_GATE_EN when it is defined.
module tb_vector_mask_sequencer;

`ifdef VMASK_SEQ_BODY_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  vsew_i;
    logic [6:0]  vl_i;
    logic        vm_i;
    logic [63:0] vmask_i;
    logic        busy_o;
    logic        slice_valid_o;
    logic        slice_ready_i;
    logic [15:0] slice_mask_o;
    logic [15:0] slice_body_o;
    logic [1:0]  slice_idx_o;
    logic        slice_last_o;
    logic        done_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  vsew;
        logic [6:0]  vl;
        logic        vm;
        logic [63:0] mask;
        int          n;
        logic [15:0] m0;
        logic [15:0] b0;
        logic [15:0] ml;
        logic [15:0] bl;
        int          bp;
        bit          hs;
    } vec_t;

    typedef struct {
        logic [15:0] mask;
        logic [15:0] body;
        logic [1:0]  idx;
        logic        last;
    } exp_t;

    vec_t tv[12];
    exp_t sb[$];

    always #5 clk = ~clk;

    vector_mask_sequencer dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start_i),
        .vsew_i        (vsew_i),
        .vl_i          (vl_i),
        .vm_i          (vm_i),
        .vmask_i       (vmask_i),
        .busy_o        (busy_o),
        .slice_valid_o (slice_valid_o),
        .slice_ready_i (slice_ready_i),
        .slice_mask_o  (slice_mask_o),
        .slice_body_o  (slice_body_o),
        .slice_idx_o   (slice_idx_o),
        .slice_last_o  (slice_last_o),
        .done_o        (done_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"},  busy_o, 0);
        chk({tag, "_valid"}, slice_valid_o, 0);
        chk({tag, "_mask"},  slice_mask_o, 0);
        chk({tag, "_body"},  slice_body_o, 0);
        chk({tag, "_idx"},   slice_idx_o, 0);
        chk({tag, "_last"},  slice_last_o, 0);
        chk({tag, "_done"},  done_o, 0);
    endtask

    // Reference model: one chunk's expected slice and the instruction's slice count.
    function automatic void model(input vec_t v, input int k,
                                  output logic [15:0] om, output logic [15:0] ob, output int n);
        int          e;
        int          vle;
        int          el;
        logic [63:0] mm;
        logic [63:0] sh;
        e   = (v.vsew <= 3'd3) ? (16 >> v.vsew) : 0;
        vle = int'(v.vl);
        if (vle > 4 * e) vle = 4 * e;
        n  = (e == 0) ? 0 : (vle + e - 1) / e;
        mm = v.vm ? 64'hFFFF_FFFF_FFFF_FFFF : v.mask;
        om = 16'h0;
        ob = 16'h0;
        for (int j = 0; j < e; j++) begin
            el    = k * e + j;
            sh    = mm >> el;
            om[j] = sh[0];
            ob[j] = (el < vle);
        end
        if (GATE) om = om & ob;
    endfunction

    task automatic run_vec(input vec_t v, input string nm);
        exp_t        it;
        logic [15:0] om, ob;
        int          n, cyc, stalls;
        bit          got_done, prev_stall;
        logic [15:0] pm, pb;
        logic [1:0]  pi;
        logic        pl;
        sb.delete();
        model(v, 0, om, ob, n);
        for (int k = 0; k < n; k++) begin
            model(v, k, om, ob, n);
            it.mask = om;
            it.body = ob;
            it.idx  = 2'(k);
            it.last = (k == n - 1);
            sb.push_back(it);
        end
        @(negedge clk);
        start_i = 1'b1; vsew_i = v.vsew; vl_i = v.vl; vm_i = v.vm; vmask_i = v.mask;
        slice_ready_i = 1'b1;
        cyc = 0; stalls = 0; got_done = 1'b0; prev_stall = 1'b0;
        pm = '0; pb = '0; pi = '0; pl = 1'b0;
        while (!got_done && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (v.hs) begin
                vsew_i  = 3'($urandom_range(0, 7));
                vl_i    = 7'($urandom_range(0, 127));
                vm_i    = 1'($urandom_range(0, 1));
                vmask_i = {$urandom, $urandom};
            end else begin
                start_i = 1'b0;
            end
            if (done_o) begin
                got_done = 1'b1;
                start_i  = 1'b0;
                chk({nm, "_done_cycle"}, 64'(cyc), 64'(v.n + 1 + stalls));
                chk({nm, "_done_valid"}, slice_valid_o, 0);
                chk({nm, "_done_busy"}, busy_o, 1);
                chk({nm, "_slices_left"}, 64'(sb.size()), 0);
            end else if (slice_valid_o) begin
                if (prev_stall) begin
                    chk({nm, "_hold_mask"}, slice_mask_o, pm);
                    chk({nm, "_hold_body"}, slice_body_o, pb);
                    chk({nm, "_hold_idx"}, slice_idx_o, pi);
                    chk({nm, "_hold_last"}, slice_last_o, pl);
                end
                if ((v.bp == 1 && slice_idx_o == 2'd1 && stalls < 3) ||
                    (v.bp == 2 && stalls < 8 && $urandom_range(0, 2) == 0)) begin
                    slice_ready_i = 1'b0;
                    stalls++;
                    prev_stall = 1'b1;
                    pm = slice_mask_o; pb = slice_body_o; pi = slice_idx_o; pl = slice_last_o;
                end else begin
                    slice_ready_i = 1'b1;
                    prev_stall = 1'b0;
                    if (sb.size() == 0) begin
                        chk({nm, "_extra_slice"}, slice_idx_o, 64'hDEAD);
                    end else begin
                        it = sb.pop_front();
                        chk({nm, "_mask"}, slice_mask_o, it.mask);
                        chk({nm, "_body"}, slice_body_o, it.body);
                        chk({nm, "_idx"}, slice_idx_o, it.idx);
                        chk({nm, "_last"}, slice_last_o, it.last);
                        if (it.idx == 2'd0) begin
                            chk({nm, "_tbl_m0"}, slice_mask_o, v.m0);
                            chk({nm, "_tbl_b0"}, slice_body_o, v.b0);
                        end
                        if (it.last) begin
                            chk({nm, "_tbl_ml"}, slice_mask_o, v.ml);
                            chk({nm, "_tbl_bl"}, slice_body_o, v.bl);
                        end
                    end
                end
            end else begin
                chk({nm, "_valid_drop"}, slice_valid_o, 1);
            end
        end
        if (!got_done) chk({nm, "_done_timeout"}, 0, 1);
        @(negedge clk);
        slice_ready_i = 1'b1;
        chk({nm, "_post_done"}, done_o, 0);
        chk({nm, "_post_busy"}, busy_o, 0);
    endtask

    initial begin
        tv[0]  = '{3'd0, 7'd64, 1'b0, 64'h0123_4567_89AB_CDEF, 4, 16'hCDEF, 16'hFFFF, 16'h0123, 16'hFFFF, 0, 1'b0};
        tv[1]  = '{3'd2, 7'd6,  1'b0, 64'h3F, 2, 16'hF, 16'hF, 16'h3, 16'h3, 0, 1'b0};
        tv[2]  = '{3'd2, 7'd6,  1'b0, 64'hFF, 2, 16'hF, 16'hF, GATE ? 16'h3 : 16'hF, 16'h3, 0, 1'b0};
        tv[3]  = '{3'd3, 7'd9,  1'b1, 64'h0, 4, 16'h3, 16'h3, 16'h3, 16'h3, 0, 1'b0};
        tv[4]  = '{3'd1, 7'd13, 1'b0, 64'hAAAA_5555, 2, 16'h55, 16'hFF, GATE ? 16'h15 : 16'h55, 16'h1F, 0, 1'b0};
        tv[5]  = '{3'd0, 7'd100, 1'b0, 64'hFFFF_0000_0000_0000, 4, 16'h0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 1'b0};
        tv[6]  = '{3'd3, 7'd1,  1'b1, 64'h0, 1, GATE ? 16'h1 : 16'h3, 16'h1, GATE ? 16'h1 : 16'h3, 16'h1, 0, 1'b0};
        tv[7]  = '{3'd1, 7'd32, 1'b0, 64'hDEAD_BEEF, 4, 16'hEF, 16'hFF, 16'hDE, 16'hFF, 1, 1'b0};
        tv[8]  = '{3'd0, 7'd0,  1'b0, 64'hFFFF, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1'b0};
        tv[9]  = '{3'd5, 7'd20, 1'b0, 64'hFFFF, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1'b0};
        tv[10] = '{3'd0, 7'd40, 1'b0, 64'h00FF_F0F0_1234_5678, 3, 16'h5678, 16'hFFFF,
                   GATE ? 16'h00F0 : 16'hF0F0, 16'h00FF, 0, 1'b1};
        tv[11] = '{3'd2, 7'd16, 1'b0, 64'h1234, 4, 16'h4, 16'hF, 16'h1, 16'hF, 2, 1'b0};

        rst = 1'b1; start_i = 1'b0; vsew_i = 3'd0; vl_i = 7'd0; vm_i = 1'b0;
        vmask_i = 64'h0; slice_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk_quiet("in_reset");
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("after_reset");

        for (int i = 0; i < 12; i++) begin
            run_vec(tv[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of an instruction, after slice 1 has been accepted.
        @(negedge clk);
        start_i = 1'b1; vsew_i = tv[0].vsew; vl_i = tv[0].vl; vm_i = tv[0].vm;
        vmask_i = tv[0].mask; slice_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("rst_run_idx0", slice_idx_o, 0);
        @(negedge clk);
        chk("rst_run_idx1", slice_idx_o, 1);
        @(negedge clk);
        chk("rst_run_valid", slice_valid_o, 1);
        rst = 1'b1;
        #1;
        chk_quiet("mid_reset");
        @(negedge clk);
        chk("mid_reset_done", done_o, 0);
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("post_mid_reset");
        run_vec(tv[0], "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
